// File: rtl/friscv_pkg.sv
// friscv_pkg: shared widths, reset vector, fetch FSM states and instruction field positions
package friscv_pkg;
    localparam int ILEN = 32;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;
    typedef enum logic {S_RUN, S_FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; the head entry is read straight out of the storage registers
module fetch_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic                   clk_in,
    input  logic                   rstn_in,
    input  logic                   flush_in,
    input  logic                   push_in,
    input  logic                   pop_in,
    input  logic [W-1:0]           data_in,
    output logic [W-1:0]           head_out,
    output logic [$clog2(DEPTH):0] count_out
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else if (flush_in) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (push_in) begin
                mem_q[wr_q] <= data_in;
                wr_q <= wr_q + AW'(1);
            end
            if (pop_in) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_in) - (AW+1)'(pop_in);
        end
    end
    assign head_out = mem_q[rd_q];
    assign count_out = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited instruction fetcher with an output buffer and redirect flushing.
// Requests never exceed free buffer slots, so every accepted response always has room.
module instr_fetch_unit
    import friscv_pkg::*;
#(
    parameter int ADDR_WIDTH = XLEN,
    parameter int INSTR_WIDTH = ILEN,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_VECTOR,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk_in,
    input  logic                   rstn_in,
    output logic                   imem_req_out,
    output logic [ADDR_WIDTH-1:0]  imem_addr_out,
    input  logic                   imem_gnt_in,
    input  logic                   imem_rvalid_in,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_in,
    output logic                   instr_valid_out,
    input  logic                   instr_ready_in,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic [6:0]             op_code_out,
    output logic [2:0]             func3_out,
    output logic [6:0]             func7_out,
    input  logic                   redirect_in,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_in
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
    fetch_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
    logic [CW-1:0] out_q, out_d, disc_q, disc_d, out_n, fifo_cnt;
    logic [CW:0] credit;
    logic req, xfer, rv_run, rv_drop, push, pop_raw, pop;
    logic [EW-1:0] head;
    assign target = redirect_pc_in & ~ADDR_WIDTH'(3);
    assign instr_valid_out = fifo_cnt != '0;
    assign pop_raw = instr_valid_out & instr_ready_in;
    assign pop = pop_raw & ~redirect_in;
    // A slot freed by this cycle's pop already counts as credit, giving one fetch per cycle.
    assign credit = {1'b0, out_q} + {1'b0, fifo_cnt} - (CW+1)'(pop_raw);
    assign req = (state_q == S_RUN) & (credit < (CW+1)'(FIFO_DEPTH));
    assign imem_req_out = rstn_in & req;
    assign imem_addr_out = fetch_pc_q;
    assign xfer = req & imem_gnt_in;
    assign rv_run = imem_rvalid_in & (state_q == S_RUN) & (out_q != '0);
    assign rv_drop = imem_rvalid_in & (state_q == S_FLUSH) & (disc_q != '0);
    assign push = rv_run & ~redirect_in;
    assign out_n = out_q + CW'(xfer) - CW'(rv_run);
    always_comb begin
        fetch_pc_d = redirect_in ? target : xfer ? fetch_pc_q + STEP : fetch_pc_q;
        resp_pc_d = redirect_in ? target : push ? resp_pc_q + STEP : resp_pc_q;
        out_d = redirect_in ? '0 : out_n;
        disc_d = disc_q - CW'(rv_drop) + (redirect_in ? out_n : '0);
        state_d = (disc_d != '0) ? S_FLUSH : S_RUN;
    end
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q <= S_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q <= '0;
            disc_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q <= resp_pc_d;
            out_q <= out_d;
            disc_q <= disc_d;
        end
    end
    fetch_fifo #(
        .W(EW),
        .DEPTH(FIFO_DEPTH),
        .RST_VAL({RESET_PC, INSTR_WIDTH'(0)})
    ) u_fifo (
        .clk_in(clk_in),
        .rstn_in(rstn_in),
        .flush_in(redirect_in),
        .push_in(push),
        .pop_in(pop),
        .data_in({resp_pc_q, imem_rdata_in}),
        .head_out(head),
        .count_out(fifo_cnt)
    );
    assign instr_out = head[INSTR_WIDTH-1:0];
    assign pc_out = head[EW-1:INSTR_WIDTH];
    assign op_code_out = instr_out[OPC_MSB:OPC_LSB];
    assign func3_out = instr_out[F3_MSB:F3_LSB];
    assign func7_out = instr_out[F7_MSB:F7_LSB];
    // A response with nothing outstanding or pending discard is a memory protocol error.
    assert property (@(posedge clk_in) disable iff (!rstn_in)
        imem_rvalid_in |-> (out_q != '0 || disc_q != '0));
endmodule
